// File: rtl/inverter_nbit_pipe.sv
// inverter_nbit_pipe
//   Registered, valid/ready handshaked conditional bit inverter. Each accepted
//   beat is XORed with an effective mask chosen by its mode and lands in a
//   single output register (one cycle of latency, full throughput). A phase
//   flop drives the alternating mode, and a saturating counter tallies
//   accepted beats that had at least one bit inverted.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_data    : operand (WIDTH)
//   in_mode    : 00 pass, 01 invert all, 10 invert by mask, 11 alternate
//   in_mask    : per-bit inversion mask, used in mode 10 only (WIDTH)
//   in_valid   : upstream beat offered
//   in_ready   : block can take a beat this cycle
//   out_data   : registered result (WIDTH)
//   out_valid  : out_data holds an undelivered beat
//   out_ready  : downstream takes out_data this cycle
//   inv_count  : accepted beats with a nonzero effective mask (CNT_W, saturating)

module inverter_nbit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_mask,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] inv_count
);

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_ALL  = 2'b01;
  localparam logic [1:0] MODE_MASK = 2'b10;
  localparam logic [1:0] MODE_ALT  = 2'b11;

  logic [WIDTH-1:0] data_q,  data_d;
  logic             valid_q, valid_d;
  logic             phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] eff_mask;

  // The output register can take a new beat whenever it is empty or is being
  // drained in this same cycle.
  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign deliver  = valid_q & out_ready;

  always_comb begin
    eff_mask = '0;
    unique case (in_mode)
      MODE_PASS: eff_mask = '0;
      MODE_ALL:  eff_mask = '1;
      MODE_MASK: eff_mask = in_mask;
      MODE_ALT:  eff_mask = phase_q ? '1 : '0;
      default:   eff_mask = '0;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (accept) begin
      // Accept wins over deliver: a simultaneous pair just reloads the
      // register and keeps valid high, so no bubble is introduced.
      data_d  = in_data ^ eff_mask;
      valid_d = 1'b1;
      if (in_mode == MODE_ALT) begin
        phase_d = ~phase_q;
      end
      // Saturate instead of wrapping.
      if ((|eff_mask) && !(&cnt_q)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (deliver) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      phase_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign inv_count = cnt_q;

endmodule

// File: tb/tb_inverter_nbit_pipe.sv
module tb_inverter_nbit_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic [WIDTH-1:0] in_mask;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] inv_count;

  int n_tests;
  int n_fail;

  inverter_nbit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_mask   (in_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inv_count (inv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Present one beat just after an edge, let it be taken at the next edge,
  // then leave the bench 1 time unit after that edge.
  task automatic send(input logic [7:0] d, input logic [1:0] m, input logic [7:0] mk);
    in_data  = d;
    in_mode  = m;
    in_mask  = mk;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // scoreboard state for the random phase
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_phase;
  logic [15:0] m_cnt;
  logic [7:0]  m_mask;
  logic        m_acc, m_dlv;
  int          n_acc, n_dlv;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_data   = 8'h5A;
    in_mode   = 2'b01;
    in_mask   = 8'h00;
    in_valid  = 1'b1;
    out_ready = 1'b0;

    // reset held with a beat offered: nothing may be accepted
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'h00);
    chk("rst_inv_count", 64'(inv_count), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    in_valid = 1'b0;
    rst      = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // mixed modes
    send(8'h00, 2'b00, 8'h00); chk("s1_pass",   64'(out_data), 64'h00);
    chk("s1_valid", 64'(out_valid), 64'd1);
    send(8'h00, 2'b01, 8'h00); chk("s1_all",    64'(out_data), 64'hFF);
    send(8'hA5, 2'b10, 8'h0F); chk("s1_mask",   64'(out_data), 64'hAA);
    send(8'hFF, 2'b01, 8'h00); chk("s1_all_ff", 64'(out_data), 64'h00);
    chk("s1_count", 64'(inv_count), 64'd3);

    // alternate mode, back-to-back
    in_data = 8'h3C; in_mode = 2'b11; in_mask = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1; chk("s2_b0", 64'(out_data), 64'h3C);
    @(posedge clk); #1; chk("s2_b1", 64'(out_data), 64'hC3);
    @(posedge clk); #1; chk("s2_b2", 64'(out_data), 64'h3C);
    @(posedge clk); #1; chk("s2_b3", 64'(out_data), 64'hC3);
    in_valid = 1'b0;
    chk("s2_count", 64'(inv_count), 64'd5);

    // backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'h55, 2'b00, 8'h00);
    chk("s3_load", 64'(out_data), 64'h55);
    in_data = 8'h11; in_mode = 2'b01; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("s3_in_ready_low", 64'(in_ready),  64'd0);
      chk("s3_hold_data",    64'(out_data),  64'h55);
      chk("s3_hold_valid",   64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    chk("s3_count_hold", 64'(inv_count), 64'd5);
    out_ready = 1'b1;
    #1;
    chk("s3_in_ready_up", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("s3_swap_data",  64'(out_data),  64'hEE);
    chk("s3_swap_valid", 64'(out_valid), 64'd1);
    chk("s3_swap_count", 64'(inv_count), 64'd6);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("s3_drain_valid", 64'(out_valid), 64'd0);
    chk("s3_drain_data",  64'(out_data),  64'hEE);

    // reset mid-transfer with phase set
    out_ready = 1'b0;
    send(8'h01, 2'b11, 8'h00);
    chk("s4_pre_data", 64'(out_data), 64'h01);
    rst = 1'b1;
    in_data = 8'h01; in_mode = 2'b11; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("s4_rst_valid", 64'(out_valid), 64'd0);
    chk("s4_rst_data",  64'(out_data),  64'h00);
    chk("s4_rst_count", 64'(inv_count), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("s4_first_alt", 64'(out_data), 64'h01);
    chk("s4_first_cnt", 64'(inv_count), 64'd0);

    // counter saturation
    in_data = 8'h00; in_mode = 2'b01; in_valid = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("s5_cnt_fffe", 64'(inv_count), 64'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("s5_cnt_sat", 64'(inv_count), 64'hFFFF);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("s5_cnt_held", 64'(inv_count), 64'hFFFF);

    // random traffic against a reference model
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_data = 8'h00; m_valid = 1'b0; m_phase = 1'b0; m_cnt = 16'h0;
    n_acc = 0; n_dlv = 0;
    for (int i = 0; i < 10000; i++) begin
      in_data   = 8'($urandom);
      in_mask   = 8'($urandom);
      in_mode   = 2'($urandom);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      m_acc = in_valid && (!m_valid || out_ready);
      m_dlv = m_valid && out_ready;
      if (m_dlv) begin
        chk("rnd_dlv_data", 64'(out_data), 64'(m_data));
        n_dlv++;
      end
      case (in_mode)
        2'b00:   m_mask = 8'h00;
        2'b01:   m_mask = 8'hFF;
        2'b10:   m_mask = in_mask;
        default: m_mask = m_phase ? 8'hFF : 8'h00;
      endcase
      @(posedge clk);
      if (m_acc) begin
        n_acc++;
        m_data  = in_data ^ m_mask;
        m_valid = 1'b1;
        if (in_mode == 2'b11) m_phase = ~m_phase;
        if (m_mask != 8'h00 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (m_dlv) begin
        m_valid = 1'b0;
      end
      #1;
      chk("rnd_out_valid", 64'(out_valid), 64'(m_valid));
      chk("rnd_out_data",  64'(out_data),  64'(m_data));
      chk("rnd_inv_count", 64'(inv_count), 64'(m_cnt));
    end
    in_valid = 1'b0;
    // every accepted beat is either delivered or still waiting
    chk("rnd_beat_balance", 64'(n_acc - n_dlv), 64'(out_valid));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inverter_nbit_pipe.md
INVERTER_NBIT_PIPE -- requirements
Module: inverter_nbit_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data path width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the inverted-beat counter.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset that is synchronous and active-high.
REQ-005 The block SHALL have port in_data, input, WIDTH bits: operand to be conditionally inverted.
REQ-006 The block SHALL have port in_mode, input, 2 bits: 00 pass, 01 invert all, 10 invert by mask, 11 alternate.
REQ-007 The block SHALL have port in_mask, input, WIDTH bits: per-bit inversion mask, used only in mode 10.
REQ-008 The block SHALL have port in_valid, input, 1 bit: upstream beat offered.
REQ-009 The block SHALL have port in_ready, output, 1 bit: block can accept a beat this cycle.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: registered result.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data holds an undelivered beat.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-013 The block SHALL have port inv_count, output, CNT_W bits: number of accepted beats with at least one bit inverted.

Function
REQ-014 Accept SHALL occur when in_valid and in_ready are both 1; deliver SHALL occur when out_valid and out_ready are both 1.
REQ-015 in_ready SHALL equal (not out_valid) or out_ready, combinationally; this gives one output register and full throughput.
REQ-016 Effective mask SHALL be: mode 00 all zeros; mode 01 all ones; mode 10 in_mask; mode 11 all ones when phase=1, else all zeros.
REQ-017 On accept, out_data SHALL load in_data XOR effective mask, and out_valid SHALL be set to 1, one cycle of latency.
REQ-018 On deliver without a simultaneous accept, out_valid SHALL clear to 0; out_data SHALL hold its value.
REQ-019 A simultaneous deliver and accept SHALL load the new beat with out_valid staying 1, with no bubble and no lost beat.
REQ-020 While out_valid=1 and out_ready=0, out_data and out_valid SHALL stay stable, and in_valid/in_data SHALL be ignored because in_ready=0.
REQ-021 The phase flop SHALL toggle only on an accept in mode 11; it SHALL hold on accepts in other modes and on idle cycles.
REQ-022 Mode and mask SHALL be sampled per beat at accept; a mode change between beats SHALL take effect on the next accepted beat.
REQ-023 inv_count SHALL increment by 1 on each accept whose effective mask is nonzero.
REQ-024 inv_count SHALL saturate at all ones and SHALL NOT wrap.
REQ-025 With WIDTH=1, the block SHALL behave as a registered, handshaked 1-bit conditional inverter; mode 10 SHALL use in_mask[0].

Reset
REQ-026 When rst=1 at a clk edge: out_valid=0, out_data=0, phase=0, inv_count=0.
REQ-027 rst SHALL override any accept or deliver in the same cycle; a beat held mid-transfer SHALL be discarded.
REQ-028 During rst=1, in_ready SHALL follow REQ-015, with out_valid=0 giving in_ready=1, but no accept SHALL take effect.
REQ-029 After rst deasserts, the first mode-11 beat SHALL pass uninverted because phase=0.

Verification (WIDTH=8, CNT_W=16)
REQ-030 Scenario: out_ready=1; beats 0x00 in mode 00, 0x00 in mode 01, 0xA5 in mode 10 with mask 0x0F, 0xFF in mode 01; expected out_data one cycle later = 0x00, 0xFF, 0xAA, 0x00; inv_count=3.
REQ-031 Scenario: mode 11, four back-to-back beats of 0x3C; expected out_data = 0x3C, 0xC3, 0x3C, 0xC3; inv_count=2.
REQ-032 Scenario: backpressure, out_ready=0 for 5 cycles with out_valid=1; expected in_ready=0, and out_data stable; then out_ready=1 with in_valid=1 on the same cycle; expected the held beat delivered and the new beat loaded, with no gap.
REQ-033 Scenario: force inv_count to 0xFFFE via 65534 mode-01 beats, then 3 more mode-01 beats; expected inv_count=0xFFFF, held.
REQ-034 Scenario: rst=1 while out_valid=1 and in_valid=1 in mode 11; expected out_valid=0, out_data=0, inv_count=0 next cycle; the next mode-11 beat 0x01 is expected to give 0x01.
REQ-035 Scenario: random mode, mask, data and out_ready for 10k cycles against a scoreboard model; expected zero mismatches and no dropped or duplicated beats.
